// File: rtl/i2c_byte_engine.sv
// rtl/i2c_byte_engine.sv - I2C data-phase engine: one byte plus ACK in four quarter-phases per bit
module i2c_byte_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_WIDTH-1:0]  clock_divisor,
  input  logic                  start,
  input  logic                  rw,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  ack_in,
  input  logic                  sda_in,
  input  logic                  scl_in,
  output logic                  sda_out,
  output logic                  scl_out,
  output logic                  data_phase,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  ack_out
);

  // Bit index must reach DATA_WIDTH, which addresses the ACK bit.
  localparam int IW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q0,
    S_Q1,
    S_Q2,
    S_Q3
  } state_t;

  state_t                state_q;
  logic [DIV_WIDTH-1:0]  ctr_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [IW-1:0]         idx_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  ack_in_q;
  logic                  sda_out_q;
  logic                  scl_out_q;
  logic                  data_phase_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic                  ack_out_q;

  logic                  tick_d;
  logic                  stall_d;
  logic                  last_bit_d;
  logic [IW-1:0]         idx_d;
  logic                  next_ack_d;
  logic [DATA_WIDTH-1:0] tx_d;
  logic                  next_sda_d;
  logic [DATA_WIDTH-1:0] rx_d;

  // Quarter timing, stretch detection and the SDA value for the bit about to start.
  always_comb begin
    tick_d     = (ctr_q == div_q);
    stall_d    = ((state_q == S_Q1) || (state_q == S_Q2)) && !scl_in;
    last_bit_d = (idx_q == IW'(DATA_WIDTH));
    idx_d      = idx_q + 1'b1;
    next_ack_d = (idx_d == IW'(DATA_WIDTH));
    // tx_q is kept MSB-aligned; shifting once exposes the next bit at the top.
    tx_d       = tx_q << 1;
    if (next_ack_d) begin
      next_sda_d = rw_q ? ack_in_q : 1'b1;
    end else begin
      next_sda_d = rw_q ? 1'b1 : tx_d[DATA_WIDTH-1];
    end
    rx_d    = rx_q << 1;
    rx_d[0] = sda_in;
  end

  // Main sequencer: state, quarter counter, latched request and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      div_q        <= '0;
      idx_q        <= '0;
      rw_q         <= 1'b0;
      tx_q         <= '0;
      ack_in_q     <= 1'b1;
      sda_out_q    <= 1'b1;
      scl_out_q    <= 1'b1;
      data_phase_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_q         <= '0;
      ack_out_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // SCL stays wherever it was left: low after a transfer, the master owns the bus.
          if (start) begin
            div_q        <= clock_divisor;
            rw_q         <= rw;
            tx_q         <= tx_data;
            ack_in_q     <= ack_in;
            idx_q        <= '0;
            ctr_q        <= '0;
            state_q      <= S_Q0;
            busy_q       <= 1'b1;
            scl_out_q    <= 1'b0;
            sda_out_q    <= rw ? 1'b1 : tx_data[DATA_WIDTH-1];
            data_phase_q <= 1'b1;
          end
        end
        S_Q0, S_Q1, S_Q2, S_Q3: begin
          if (stall_d) begin
            // A slave holding SCL low freezes the quarter in place.
            ctr_q <= ctr_q;
          end else if (!tick_d) begin
            ctr_q <= ctr_q + 1'b1;
          end else begin
            ctr_q <= '0;
            case (state_q)
              S_Q0: begin
                state_q   <= S_Q1;
                scl_out_q <= 1'b1;
              end
              S_Q1: begin
                state_q <= S_Q2;
              end
              S_Q2: begin
                // SDA is sampled at the end of SCL high.
                state_q   <= S_Q3;
                scl_out_q <= 1'b0;
                if (!last_bit_d) begin
                  if (rw_q) begin
                    rx_q <= rx_d;
                  end
                end else if (!rw_q) begin
                  ack_out_q <= sda_in;
                end
              end
              default: begin
                if (!last_bit_d) begin
                  idx_q        <= idx_d;
                  tx_q         <= tx_d;
                  state_q      <= S_Q0;
                  sda_out_q    <= next_sda_d;
                  data_phase_q <= !next_ack_d;
                end else begin
                  state_q      <= S_IDLE;
                  done_q       <= 1'b1;
                  busy_q       <= 1'b0;
                  sda_out_q    <= 1'b1;
                  data_phase_q <= 1'b0;
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= S_IDLE;
          ctr_q   <= '0;
        end
      endcase
    end
  end

  assign sda_out    = sda_out_q;
  assign scl_out    = scl_out_q;
  assign data_phase = data_phase_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rx_data    = rx_q;
  assign ack_out    = ack_out_q;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb/tb_i2c_byte_engine.sv - randomized self-checking bench for i2c_byte_engine with a bus-level slave model
module tb_i2c_byte_engine;

  localparam int DW  = 8;
  localparam int DVW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DVW-1:0]  clock_divisor;
  logic            start;
  logic            rw;
  logic [DW-1:0]   tx_data;
  logic            ack_in;
  logic            sda_in;
  logic            scl_in;
  logic            sda_out;
  logic            scl_out;
  logic            data_phase;
  logic            busy;
  logic            done;
  logic [DW-1:0]   rx_data;
  logic            ack_out;

  // Slave model state: mode, byte it returns, ACK it gives, and which bit it is on.
  logic            s_rw;
  logic [DW-1:0]   s_byte;
  logic            s_ack;
  int              s_cnt;
  logic            slave_drive;
  logic            stretch;

  int n_checks;
  int n_errors;
  int n_done;
  int exp_done;

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and slave on both lines.
  assign sda_in = sda_out & slave_drive;
  assign scl_in = scl_out & ~stretch;

  always_comb begin
    slave_drive = 1'b1;
    if (s_cnt < DW) begin
      if (s_rw) slave_drive = s_byte[DW-1-s_cnt];
    end else if (!s_rw) begin
      slave_drive = s_ack;
    end
  end

  always @(negedge clk) begin
    if (rst_n && done) n_done++;
  end

  i2c_byte_engine #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clock_divisor (clock_divisor),
    .start         (start),
    .rw            (rw),
    .tx_data       (tx_data),
    .ack_in        (ack_in),
    .sda_in        (sda_in),
    .scl_in        (scl_in),
    .sda_out       (sda_out),
    .scl_out       (scl_out),
    .data_phase    (data_phase),
    .busy          (busy),
    .done          (done),
    .rx_data       (rx_data),
    .ack_out       (ack_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".sda"},  sda_out, 1);
    check({tag, ".scl"},  scl_out, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".dp"},   data_phase, 0);
  endtask

  // One byte transfer driven from a negedge; returns on the negedge where done is seen,
  // or right after an injected reset when abort_bit >= 0.
  task automatic run(input logic r, input logic [DW-1:0] tx, input logic [DVW-1:0] dv,
                     input logic ai, input logic [DW-1:0] sb, input logic sa,
                     input int st_bit, input int st_len, input bit mid_start,
                     input int abort_bit, input int gap, input string tag);
    logic [DW:0] seq_sda;
    logic [DW:0] seq_dp;
    logic [DW:0] exp_sda;
    logic [DW:0] exp_dp;
    int cnt;
    int nbits;
    int left;
    int abort_left;
    int exp_len;
    bit prev;
    bit timed_out;
    seq_sda = '0;
    seq_dp  = '0;
    repeat (gap) @(negedge clk);
    rw = r; tx_data = tx; clock_divisor = dv; ack_in = ai;
    s_rw = r; s_byte = sb; s_ack = sa; s_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_start"}, busy, 1);
    prev = scl_out;
    cnt = 0; nbits = 0; left = 0; abort_left = -1; timed_out = 0;
    exp_len = 4 * (DW + 1) * (int'(dv) + 1) + st_len;
    while (1) begin
      @(negedge clk);
      cnt++;
      if (mid_start && cnt == 3) begin
        start = 1'b1; rw = ~r; tx_data = ~tx; clock_divisor = dv + 3; ack_in = ~ai;
      end
      if (mid_start && cnt == 4) start = 1'b0;
      if (done) break;
      if (cnt > exp_len + 50) begin
        timed_out = 1;
        break;
      end
      if (left > 0) begin
        left--;
        if (left == 0) stretch = 1'b0;
      end
      if (abort_left > 0) begin
        abort_left--;
        if (abort_left == 0) begin
          #2 rst_n = 1'b0;
          #1 check_reset_outputs({tag, ".abort"});
          @(negedge clk);
          rst_n = 1'b1; stretch = 1'b0; s_cnt = 0;
          return;
        end
      end
      if (prev && !scl_out) s_cnt++;
      if (!prev && scl_out) begin
        if (nbits <= DW) begin
          seq_sda[nbits] = sda_out;
          seq_dp[nbits]  = data_phase;
        end
        nbits++;
        if (s_cnt == st_bit && st_len > 0) begin
          stretch = 1'b1;
          left = st_len;
        end
        if (s_cnt == abort_bit) abort_left = int'(dv) + 1;
      end
      prev = scl_out;
    end
    if (timed_out) begin
      check({tag, ".timeout"}, 0, 1);
      return;
    end
    for (int k = 0; k <= DW; k++) begin
      if (k < DW) begin
        exp_sda[k] = r ? 1'b1 : tx[DW-1-k];
        exp_dp[k]  = 1'b1;
      end else begin
        exp_sda[k] = r ? ai : 1'b1;
        exp_dp[k]  = 1'b0;
      end
    end
    exp_done++;
    check({tag, ".len"},   cnt, exp_len);
    check({tag, ".nbits"}, nbits, DW + 1);
    check({tag, ".sda"},   seq_sda, exp_sda);
    check({tag, ".dp"},    seq_dp, exp_dp);
    check({tag, ".busy_done"}, busy, 0);
    check({tag, ".scl_hold"},  scl_out, 0);
    check({tag, ".sda_rel"},   sda_out, 1);
    if (r) check({tag, ".rx"}, rx_data, sb);
    else   check({tag, ".ack"}, ack_out, sa);
  endtask

  initial begin
    int cnt;
    n_checks = 0; n_errors = 0; n_done = 0; exp_done = 0;
    start = 0; rw = 0; tx_data = '0; ack_in = 1; clock_divisor = '0;
    s_rw = 0; s_byte = '0; s_ack = 1; s_cnt = 0; stretch = 0;
    #12;
    check_reset_outputs("reset");
    check("reset.rx", rx_data, 0);
    check("reset.ack", ack_out, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b0, 8'hA5, 16'd0, 1'b0, 8'h00, 1'b0, -1, 0, 0, -1, 2, "t1_write");
    run(1'b1, 8'h00, 16'd3, 1'b0, 8'h3C, 1'b1, -1, 0, 0, -1, 2, "t2_read");
    run(1'b0, 8'h6E, 16'd1, 1'b1, 8'h00, 1'b0, 2, 10, 0, -1, 2, "t3_stretch");

    // Widest divisor: bit 0 Q0 must last exactly 2^DVW cycles before SCL rises.
    @(negedge clk);
    rw = 0; tx_data = 8'h80; clock_divisor = 16'hFFFF; ack_in = 1;
    s_rw = 0; s_cnt = 0; start = 1;
    @(negedge clk);
    start = 0;
    cnt = 0;
    while (!scl_out && cnt < 70000) begin
      @(negedge clk);
      cnt++;
    end
    check("t4.q0_len", cnt, 65536);
    check("t4.sda", sda_out, 1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b0, 8'hC3, 16'd2, 1'b1, 8'h00, 1'b1, -1, 0, 0, 4, 2, "t5_abort");
    run(1'b1, 8'h00, 16'd1, 1'b1, 8'h96, 1'b0, -1, 0, 0, -1, 2, "t5_clean");

    run(1'b0, 8'h5A, 16'd1, 1'b0, 8'h00, 1'b0, -1, 0, 1, -1, 2, "t6_first");
    run(1'b1, 8'h00, 16'd0, 1'b1, 8'hE1, 1'b1, -1, 0, 0, -1, 0, "t6_b2b");

    for (int i = 0; i < 10; i++) begin
      logic          rr;
      logic [DW-1:0] tt;
      logic [DW-1:0] sb;
      int            sl;
      rr = 1'($urandom_range(0, 1));
      tt = DW'($urandom);
      sb = DW'($urandom);
      sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
      run(rr, tt, DVW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), sb,
          1'($urandom_range(0, 1)), int'($urandom_range(0, DW)), sl,
          bit'($urandom_range(0, 1)), -1, int'($urandom_range(0, 2)),
          $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    @(negedge clk);
    check("done_count", n_done, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
